// File: rtl/pattern_scan_pkg.sv
// Shared types for the bit-serial pattern scan controller.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_match_core.sv
// Mealy matcher over a serial bit stream: holds the bit history and fill level,
// flags a match combinationally on the current bit.
module pattern_match_core
  import pattern_scan_pkg::*;
#(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             match_c
);

  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_q;
  logic [FILL_W-1:0] fill_q;

  assign match_c = valid && (fill_q >= FILL_MAX) && ({hist_q, bit_in} == pattern);

  // Without overlap a match consumes its bits, so the window restarts empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (valid) begin
      if (match_c && !overlap) begin
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= (PAT_W-1)'({hist_q, bit_in});
        fill_q <= (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit sequencer feeding the pattern matcher; counts matches per run and
// ends the run on the last word or when the match threshold is reached.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_threshold,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = $clog2(WORD_W);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q;
  logic               last_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PAT_W-1:0]   pat_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   thr_q;

  logic clear_c;
  logic accept_c;
  logic thr_hit_c;
  logic match_c;

  pattern_match_core #(.PAT_W(PAT_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_in  (bit_out),
    .valid   (bit_valid),
    .pattern (pat_q),
    .overlap (ovl_q),
    .clear   (clear_c),
    .match_c (match_c)
  );

  assign match = match_c;

  // Next-state decode; the threshold exit wins over the word-boundary exits.
  always_comb begin
    state_d   = state_q;
    clear_c   = 1'b0;
    accept_c  = 1'b0;
    thr_hit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear_c = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        accept_c = in_valid && in_ready;
        if (accept_c) state_d = SHIFT;
      end
      SHIFT: begin
        thr_hit_c = (thr_q != '0) && match_c &&
                    (({1'b0, match_count} + (CNT_W+1)'(1)) == {1'b0, thr_q});
        if (thr_hit_c)         state_d = DONE;
        else if (idx_q == '0)  state_d = last_q ? DONE : LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      pat_q       <= '0;
      ovl_q       <= 1'b0;
      thr_q       <= '0;
      match_count <= '0;
      in_ready    <= 1'b0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == LOAD);
      bit_valid <= (state_d == SHIFT);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);

      if (clear_c) begin
        pat_q       <= cfg_pattern;
        ovl_q       <= cfg_overlap;
        thr_q       <= cfg_threshold;
        match_count <= '0;
      end else if ((state_q == SHIFT) && match_c && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end

      if (accept_c) begin
        word_q  <= in_data;
        last_q  <= in_last;
        idx_q   <= IDX_W'(WORD_W - 1);
        bit_out <= in_data[WORD_W-1];
      end else if ((state_q == SHIFT) && (state_d == SHIFT)) begin
        word_q  <= word_q << 1;
        idx_q   <= idx_q - IDX_W'(1);
        bit_out <= word_q[WORD_W-2];
      end else begin
        bit_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench: a string-matching reference model queues the expected bit
// stream and run totals; a negedge monitor checks everything the DUT presents.
module tb_pattern_scan_ctrl;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 8;

  logic              clk, rst_n, start, cfg_overlap, in_valid, in_last;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_threshold;
  logic [WORD_W-1:0] in_data;
  logic              in_ready, bit_out, bit_valid, match, busy, done;
  logic [CNT_W-1:0]  match_count;

  pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_pattern   (cfg_pattern),
    .cfg_overlap   (cfg_overlap),
    .cfg_threshold (cfg_threshold),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .bit_out       (bit_out),
    .bit_valid     (bit_valid),
    .match         (match),
    .match_count   (match_count),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic m;
    logic end_run;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  int       cnt_exp_q[$];
  int       n_cmp = 0;
  int       n_err = 0;
  bit       mon_en = 1'b0;
  bit       pend_done = 1'b0;
  bit       pend_acc = 1'b0;

  // Reference model state: recent bits since run start or last consumed match.
  bit               mh[$];
  int               mcount;
  int               mthr;
  logic [PAT_W-1:0] mpat;
  bit               movl;
  logic [WORD_W-1:0] rw[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_word(input logic [WORD_W-1:0] w, input bit is_last, output bit stop);
    stop = 1'b0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      bit               b, m, hit;
      logic [PAT_W-1:0] v;
      exp_bit_t         e;
      b = w[i];
      mh.push_back(b);
      if (mh.size() > PAT_W) void'(mh.pop_front());
      m = 1'b0;
      v = '0;
      if (mh.size() == PAT_W) begin
        for (int j = 0; j < PAT_W; j++) v[PAT_W-1-j] = mh[j];
        m = (v == mpat);
      end
      hit = 1'b0;
      if (m) begin
        if (mcount < (1 << CNT_W) - 1) mcount++;
        if (!movl) mh.delete();
        hit = (mthr != 0) && (mcount == mthr);
      end
      e.b = b;
      e.m = m;
      e.end_run = hit || (i == 0 && is_last);
      exp_q.push_back(e);
      if (e.end_run) begin
        cnt_exp_q.push_back(mcount);
        stop = 1'b1;
        return;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'(ok), 1);
    tick();
  endtask

  task automatic do_run(input logic [PAT_W-1:0] pat, input bit ovl, input logic [CNT_W-1:0] thr,
                        input int idle_valid, input int load_gap, input bit extra_start,
                        input bit last_final, input int max_delay);
    bit stop, ok, lst;
    int n_rdy;
    wait_idle();
    if (idle_valid > 0) begin
      in_valid = 1'b1;
      in_data  = WORD_W'($urandom);
      in_last  = 1'($urandom);
      for (int c = 0; c < idle_valid; c++) begin
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);
        chk("idle_bit_valid", 32'(bit_valid), 0);
      end
      tick();
      in_valid = 1'b0;
    end
    cfg_pattern = pat;
    cfg_overlap = ovl;
    cfg_threshold = thr;
    mpat = pat; movl = ovl; mthr = int'(thr); mcount = 0; mh.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble config after start: the run must keep the latched values.
    cfg_pattern   = PAT_W'($urandom);
    cfg_overlap   = 1'($urandom);
    cfg_threshold = CNT_W'($urandom);
    for (int c = 0; c < load_gap; c++) begin
      @(negedge clk);
      chk("load_hold_ready", 32'(in_ready), 1);
      chk("load_hold_busy", 32'(busy), 1);
    end
    if (load_gap > 0) tick();
    stop = 1'b0;
    for (int k = 0; k < rw.size() && !stop; k++) begin
      lst = last_final && (k == rw.size() - 1);
      model_word(rw[k], lst, stop);
      for (int d = $urandom_range(0, max_delay); d > 0; d--) tick();
      in_data = rw[k];
      in_last = lst;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        @(negedge clk);
        if (in_ready) begin
          tick();
          ok = 1'b1;
        end
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 32'(ok), 1);
      if (extra_start && k == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    n_rdy = 0;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) n_rdy++;
      if (!busy) ok = 1'b1;
    end
    chk("run_end_timeout", 32'(ok), 1);
    chk("no_reload_after_end", 32'(n_rdy), 0);
    chk("held_count", 32'(match_count), 32'(mcount));
  endtask

  // Monitor: pops expected bits whenever the DUT presents one.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend_done) begin
          pend_done = 1'b0;
          chk("done_pulse", 32'(done), 1);
          chk("done_bit_valid", 32'(bit_valid), 0);
          if (cnt_exp_q.size() > 0) chk("final_count", 32'(match_count), 32'(cnt_exp_q.pop_front()));
          else chk("count_queue_empty", 1, 0);
        end else if (done) begin
          chk("spurious_done", 32'(done), 0);
        end
        if (pend_acc) begin
          pend_acc = 1'b0;
          chk("first_bit_latency", 32'(bit_valid), 1);
        end
        if (bit_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_bit", 1, 0);
          end else begin
            exp_bit_t e;
            e = exp_q.pop_front();
            chk("bit_out", 32'(bit_out), 32'(e.b));
            chk("match", 32'(match), 32'(e.m));
            if (e.end_run) pend_done = 1'b1;
          end
        end else if (match) begin
          chk("match_without_bit", 32'(match), 0);
        end
        if (in_valid && in_ready) pend_acc = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PAT_W-1:0] p;
    logic [CNT_W-1:0] th;
    int nw;
    int bvc;
    bit ok;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b0; cfg_threshold = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_bit_valid", 32'(bit_valid), 0);
    chk("rst_bit_out", 32'(bit_out), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(match_count), 0);
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;

    rw = '{8'hDA};
    do_run(4'b1101, 1'b1, 8'd0, 0, 0, 1'b0, 1'b1, 0);
    chk("tp_overlap_count", 32'(match_count), 2);

    rw = '{8'hDA};
    do_run(4'b1101, 1'b0, 8'd0, 0, 0, 1'b0, 1'b1, 0);
    chk("tp_no_overlap_count", 32'(match_count), 1);

    rw = '{8'h03, 8'h40};
    do_run(4'b1101, 1'b1, 8'd0, 0, 0, 1'b0, 1'b1, 0);
    chk("tp_cross_word_count", 32'(match_count), 1);

    rw = '{8'hDD, 8'hFF};
    do_run(4'b1101, 1'b1, 8'd1, 0, 0, 1'b0, 1'b0, 0);
    chk("tp_early_stop_count", 32'(match_count), 1);

    rw = '{8'hB6, 8'h5D};
    do_run(4'b1011, 1'b1, 8'd0, 3, 5, 1'b1, 1'b1, 0);

    rw.delete();
    for (int i = 0; i < 40; i++) rw.push_back(8'h00);
    do_run(4'b0000, 1'b1, 8'd0, 0, 0, 1'b0, 1'b1, 0);
    chk("saturated_count", 32'(match_count), 255);

    // Asynchronous reset in the middle of a word.
    wait_idle();
    mon_en = 1'b0;
    cfg_pattern = 4'b1111; cfg_overlap = 1'b1; cfg_threshold = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_data = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bvc = 0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bit_valid) bvc++;
      if (bvc == 5) ok = 1'b1;
    end
    chk("reset_reach_bit4", 32'(ok), 1);
    chk("pre_reset_match", 32'(match), 1);
    chk("pre_reset_count", 32'(match_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bit_valid", 32'(bit_valid), 0);
    chk("arst_bit_out", 32'(bit_out), 0);
    chk("arst_match", 32'(match), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_count", 32'(match_count), 0);
    tick();
    rst_n = 1'b1;
    exp_q.delete(); cnt_exp_q.delete(); pend_done = 1'b0; pend_acc = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_idle_busy", 32'(busy), 0);
    chk("post_reset_idle_ready", 32'(in_ready), 0);
    mon_en = 1'b1;

    for (int r = 0; r < 50; r++) begin
      p  = PAT_W'($urandom);
      th = ($urandom_range(0, 2) == 0) ? CNT_W'($urandom_range(1, 4)) : '0;
      nw = $urandom_range(1, 4);
      rw.delete();
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 1) == 1) rw.push_back({p, p} ^ WORD_W'(1 << $urandom_range(0, 9)));
        else rw.push_back(WORD_W'($urandom));
      end
      do_run(p, 1'($urandom), th, $urandom_range(0, 1), $urandom_range(0, 2),
             1'($urandom), 1'b1, 2);
    end

    repeat (5) @(negedge clk);
    chk("bits_left_over", 32'(exp_q.size()), 0);
    chk("counts_left_over", 32'(cnt_exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
